line_window_ctrl: RTL and testbench

//  Sequencer for the census stereo line-buffer datapath. Tracks frame/line/pixel position from

---
 rtl/line_window_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_line_window_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/line_window_ctrl.sv
// Line-buffer sequencer for the census stereo datapath: tracks frame/line/pixel
// position, drives line-RAM addressing and slot selection, and flags window validity.
module line_window_ctrl #(
    parameter int PX_CNT_DEPTH       = 9,
    parameter int LINE_CNT_DEPTH     = 9,
    parameter int PIXELS_PER_LINE    = 499,
    parameter int LINES_PER_FRAME    = 499,
    parameter int HAMMING_BLOCK_SIZE = 12,
    parameter int SLOT_DEPTH         = 3,
    parameter int PIPE_LAT           = 3
) (
    input  logic                          pxclk,
    input  logic                          reset,
    input  logic                          iHref,
    input  logic                          iVsync,
    output logic [PX_CNT_DEPTH:0]         oPxAddr,
    output logic                          oWe,
    output logic [HAMMING_BLOCK_SIZE:0]   oLineSel,
    output logic [SLOT_DEPTH:0]           oRot,
    output logic [LINE_CNT_DEPTH:0]       oLineCnt,
    output logic                          oWinValid,
    output logic                          oDispValid,
    output logic                          oFrameStart,
    output logic                          oFrameDone,
    output logic                          oOverrun
);

    localparam int PXW   = PX_CNT_DEPTH + 1;
    localparam int LNW   = LINE_CNT_DEPTH + 1;
    localparam int SLW   = SLOT_DEPTH + 1;
    localparam int NSLOT = HAMMING_BLOCK_SIZE + 1;

    localparam logic [PX_CNT_DEPTH:0]       PX_ZERO   = {PXW{1'b0}};
    localparam logic [PX_CNT_DEPTH:0]       PX_ONE    = {{(PXW-1){1'b0}}, 1'b1};
    localparam logic [PX_CNT_DEPTH:0]       PX_LAST   = PXW'(PIXELS_PER_LINE);
    localparam logic [PX_CNT_DEPTH:0]       PX_HB     = PXW'(HAMMING_BLOCK_SIZE);
    localparam logic [LINE_CNT_DEPTH:0]     LINE_ZERO = {LNW{1'b0}};
    localparam logic [LINE_CNT_DEPTH:0]     LINE_ONE  = {{(LNW-1){1'b0}}, 1'b1};
    localparam logic [LINE_CNT_DEPTH:0]     LINE_LAST = LNW'(LINES_PER_FRAME);
    localparam logic [LINE_CNT_DEPTH:0]     LINE_HB   = LNW'(HAMMING_BLOCK_SIZE);
    localparam logic [SLOT_DEPTH:0]         SLOT_ZERO = {SLW{1'b0}};
    localparam logic [SLOT_DEPTH:0]         SLOT_ONE  = {{(SLW-1){1'b0}}, 1'b1};
    localparam logic [SLOT_DEPTH:0]         SLOT_LAST = SLW'(HAMMING_BLOCK_SIZE);
    localparam logic [HAMMING_BLOCK_SIZE:0] SEL_ZERO  = {NSLOT{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HBLANK = 2'd1,
        LINE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Wrap counter for the rotating slot index; avoids a modulo.
    function automatic logic [SLOT_DEPTH:0] slot_inc(input logic [SLOT_DEPTH:0] s);
        logic [SLOT_DEPTH:0] r;
        if (s == SLOT_LAST) begin
            r = SLOT_ZERO;
        end else begin
            r = s + SLOT_ONE;
        end
        return r;
    endfunction

    function automatic logic [HAMMING_BLOCK_SIZE:0] one_hot(input logic [SLOT_DEPTH:0] s);
        logic [HAMMING_BLOCK_SIZE:0] v;
        v    = SEL_ZERO;
        v[s] = 1'b1;
        return v;
    endfunction

    state_t                        state_r, state_s;
    logic                          href_q_r, vsync_q_r;
    logic [PX_CNT_DEPTH:0]         px_cnt_r, px_cnt_s;
    logic [LINE_CNT_DEPTH:0]       line_cnt_r, line_cnt_s;
    logic [SLOT_DEPTH:0]           slot_r, slot_s;
    logic                          we_r, we_s;
    logic                          overrun_r, overrun_s;
    logic                          frame_start_r, frame_start_s;
    logic                          frame_done_r, frame_done_s;
    logic [HAMMING_BLOCK_SIZE:0]   line_sel_r, line_sel_s;
    logic [SLOT_DEPTH:0]           rot_r, rot_s;
    logic                          win_valid_r, win_valid_s;
    logic [PIPE_LAT-1:0]           disp_sr_r;
    logic                          href_rise_s, vsync_rise_s;

    assign href_rise_s  = iHref & ~href_q_r;
    assign vsync_rise_s = iVsync & ~vsync_q_r;

    // Next-state and next-output logic; a vsync rise overrides everything else.
    always_comb begin
        state_s       = state_r;
        px_cnt_s      = px_cnt_r;
        line_cnt_s    = line_cnt_r;
        slot_s        = slot_r;
        we_s          = 1'b0;
        overrun_s     = overrun_r;
        frame_start_s = 1'b0;
        frame_done_s  = 1'b0;
        if (vsync_rise_s) begin
            state_s       = HBLANK;
            px_cnt_s      = PX_ZERO;
            line_cnt_s    = LINE_ZERO;
            slot_s        = SLOT_ZERO;
            overrun_s     = 1'b0;
            frame_start_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                HBLANK: begin
                    if (href_rise_s) begin
                        state_s  = LINE;
                        px_cnt_s = PX_ZERO;
                        we_s     = 1'b1;
                    end else begin
                        state_s = HBLANK;
                    end
                end
                LINE: begin
                    if (iHref) begin
                        // Too many pixels: freeze the address and stop writing.
                        if (px_cnt_r == PX_LAST) begin
                            overrun_s = 1'b1;
                            we_s      = 1'b0;
                        end else begin
                            px_cnt_s = px_cnt_r + PX_ONE;
                            we_s     = 1'b1;
                        end
                    end else begin
                        line_cnt_s = line_cnt_r + LINE_ONE;
                        slot_s     = slot_inc(slot_r);
                        if (line_cnt_r == LINE_LAST) begin
                            state_s      = DONE;
                            frame_done_s = 1'b1;
                        end else begin
                            state_s = HBLANK;
                        end
                    end
                end
                DONE: begin
                    state_s = DONE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Derived outputs computed from next-state values so they register in step.
    always_comb begin
        line_sel_s  = SEL_ZERO;
        if ((state_s == LINE) || (state_s == HBLANK)) begin
            line_sel_s = one_hot(slot_s);
        end else begin
            line_sel_s = SEL_ZERO;
        end
        rot_s       = slot_inc(slot_s);
        win_valid_s = we_s & (line_cnt_s >= LINE_HB) & (px_cnt_s >= PX_HB);
    end

    // State and output registers.
    always_ff @(posedge pxclk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            href_q_r      <= 1'b0;
            vsync_q_r     <= 1'b0;
            px_cnt_r      <= PX_ZERO;
            line_cnt_r    <= LINE_ZERO;
            slot_r        <= SLOT_ZERO;
            we_r          <= 1'b0;
            overrun_r     <= 1'b0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            line_sel_r    <= SEL_ZERO;
            rot_r         <= SLOT_ZERO;
            win_valid_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            href_q_r      <= iHref;
            vsync_q_r     <= iVsync;
            px_cnt_r      <= px_cnt_s;
            line_cnt_r    <= line_cnt_s;
            slot_r        <= slot_s;
            we_r          <= we_s;
            overrun_r     <= overrun_s;
            frame_start_r <= frame_start_s;
            frame_done_r  <= frame_done_s;
            line_sel_r    <= line_sel_s;
            rot_r         <= rot_s;
            win_valid_r   <= win_valid_s;
        end
    end

    // Disparity-valid delay line; drains freely across frame restarts.
    always_ff @(posedge pxclk or negedge reset) begin
        if (!reset) begin
            disp_sr_r <= {PIPE_LAT{1'b0}};
        end else begin
            disp_sr_r[0] <= win_valid_r;
            for (int i = 1; i < PIPE_LAT; i++) begin
                disp_sr_r[i] <= disp_sr_r[i-1];
            end
        end
    end

    assign oPxAddr     = px_cnt_r;
    assign oWe         = we_r;
    assign oLineSel    = line_sel_r;
    assign oRot        = rot_r;
    assign oLineCnt    = line_cnt_r;
    assign oWinValid   = win_valid_r;
    assign oDispValid  = disp_sr_r[PIPE_LAT-1];
    assign oFrameStart = frame_start_r;
    assign oFrameDone  = frame_done_r;
    assign oOverrun    = overrun_r;

endmodule

// File: tb/tb_line_window_ctrl.sv
// Self-checking bench for line_window_ctrl: directed frame scenarios and random
// href/vsync activity compared every cycle against a frame-position reference model.
module tb_line_window_ctrl;

    localparam int PPL = 499;
    localparam int LPF = 499;
    localparam int HB  = 12;
    localparam int NS  = HB + 1;

    logic        pxclk;
    logic        reset;
    logic        iHref;
    logic        iVsync;
    logic [9:0]  oPxAddr;
    logic        oWe;
    logic [12:0] oLineSel;
    logic [3:0]  oRot;
    logic [9:0]  oLineCnt;
    logic        oWinValid;
    logic        oDispValid;
    logic        oFrameStart;
    logic        oFrameDone;
    logic        oOverrun;

    line_window_ctrl dut (
        .pxclk(pxclk), .reset(reset), .iHref(iHref), .iVsync(iVsync),
        .oPxAddr(oPxAddr), .oWe(oWe), .oLineSel(oLineSel), .oRot(oRot),
        .oLineCnt(oLineCnt), .oWinValid(oWinValid), .oDispValid(oDispValid),
        .oFrameStart(oFrameStart), .oFrameDone(oFrameDone), .oOverrun(oOverrun)
    );

    initial pxclk = 1'b0;
    always #5 pxclk = ~pxclk;

    int errors = 0;
    int checks = 0;

    // Reference model: position within the frame, tracked as plain integers.
    bit          m_in_frame, m_in_line, m_hq, m_vq;
    int          m_line, m_cnt;
    logic [2:0]  m_hist;
    logic [9:0]  e_addr, e_line;
    logic [12:0] e_sel;
    logic [3:0]  e_rot;
    logic        e_we, e_ov, e_fs, e_fd, e_win, e_disp;

    task automatic model_reset();
        m_in_frame = 1'b0; m_in_line = 1'b0; m_hq = 1'b0; m_vq = 1'b0;
        m_line = 0; m_cnt = 0; m_hist = 3'b000;
        e_addr = 10'd0; e_line = 10'd0; e_sel = 13'd0; e_rot = 4'd0;
        e_we = 1'b0; e_ov = 1'b0; e_fs = 1'b0; e_fd = 1'b0; e_win = 1'b0; e_disp = 1'b0;
    endtask

    task automatic model_update(input bit h, input bit v);
        bit vr, hr;
        vr = v && !m_vq;
        hr = h && !m_hq;
        e_fs = 1'b0; e_fd = 1'b0; e_we = 1'b0;
        if (vr) begin
            m_in_frame = 1'b1; m_in_line = 1'b0; m_line = 0;
            e_addr = 10'd0; e_ov = 1'b0; e_fs = 1'b1;
        end else if (m_in_frame) begin
            if (m_in_line) begin
                if (h) begin
                    if (m_cnt <= PPL) begin
                        e_addr = 10'(m_cnt); e_we = 1'b1;
                    end else begin
                        e_ov = 1'b1;
                    end
                    m_cnt++;
                end else begin
                    m_in_line = 1'b0;
                    m_line++;
                    if (m_line == LPF + 1) begin
                        m_in_frame = 1'b0; e_fd = 1'b1;
                    end
                end
            end else if (hr) begin
                m_in_line = 1'b1; e_addr = 10'd0; e_we = 1'b1; m_cnt = 1;
            end
        end
        m_hq = h; m_vq = v;
        e_line = 10'(m_line);
        e_sel  = m_in_frame ? (13'd1 << (m_line % NS)) : 13'd0;
        e_rot  = 4'(((m_line % NS) + 1) % NS);
        e_win  = e_we && (m_line >= HB) && (int'(e_addr) >= HB);
        e_disp = m_hist[2];
        m_hist = {m_hist[1:0], e_win};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("addr",   32'(oPxAddr),     32'(e_addr));
        chk("we",     32'(oWe),         32'(e_we));
        chk("sel",    32'(oLineSel),    32'(e_sel));
        chk("rot",    32'(oRot),        32'(e_rot));
        chk("line",   32'(oLineCnt),    32'(e_line));
        chk("win",    32'(oWinValid),   32'(e_win));
        chk("disp",   32'(oDispValid),  32'(e_disp));
        chk("fstart", 32'(oFrameStart), 32'(e_fs));
        chk("fdone",  32'(oFrameDone),  32'(e_fd));
        chk("ovr",    32'(oOverrun),    32'(e_ov));
    endtask

    task automatic step(input bit h, input bit v);
        iHref  = h;
        iVsync = v;
        @(posedge pxclk);
        model_update(h, v);
        #1;
        check_all();
    endtask

    task automatic vsync_pulse();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic do_line(input int len, input int gap);
        for (int i = 0; i < len; i++) step(1'b1, 1'b0);
        for (int i = 0; i < gap; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        bit h, v;
        reset = 1'b0; iHref = 1'b0; iVsync = 1'b0;
        model_reset();
        repeat (3) @(posedge pxclk);
        #1 check_all();
        #3 reset = 1'b1;

        // Href before any vsync is ignored.
        for (int i = 0; i < 30; i++) step(1'($urandom_range(0, 1)), 1'b0);
        step(1'b0, 1'b0);

        // Four full-width lines: no window yet.
        vsync_pulse();
        for (int l = 0; l < 4; l++) do_line(PPL + 1, $urandom_range(1, 4));

        // Fourteen lines: slot wrap and first valid window.
        vsync_pulse();
        for (int l = 0; l < 14; l++) do_line(PPL + 1, $urandom_range(1, 4));

        // Over-long line, then overrun must stay sticky until next vsync.
        vsync_pulse();
        do_line(PPL + 6, 3);
        do_line($urandom_range(5, 40), 3);
        vsync_pulse();
        do_line(20, 2);

        // Vsync coincident with href rise on line 7.
        vsync_pulse();
        for (int l = 0; l < 7; l++) do_line($urandom_range(15, 30), $urandom_range(1, 3));
        step(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        do_line(25, 2);
        do_line(25, 2);

        // Asynchronous reset mid-line at pixel 37.
        vsync_pulse();
        do_line(20, 2);
        for (int i = 0; i < 38; i++) step(1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge pxclk);
        #1 check_all();
        #3 reset = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        do_line(10, 2);

        // Full frame of short lines, then href ignored after done.
        vsync_pulse();
        for (int l = 0; l <= LPF; l++) do_line($urandom_range(1, 16), $urandom_range(1, 2));
        for (int l = 0; l < 5; l++) do_line(8, 2);
        vsync_pulse();
        do_line(14, 2);

        // Random href/vsync activity.
        h = 1'b0; v = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 39) == 0) h = ~h;
            if ($urandom_range(0, 1499) == 0) v = ~v;
            step(h, v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
